// File: rtl/seven_segment_decoder.sv
// Recovers hex digits from a multiplexed, active-low seven-segment display bus.
// A digit is captured once its anode/segment pattern has been stable for STABLE_CYCLES samples.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pos,
  input  logic [7:0]  segments,
  input  logic        err_clr,
  output logic [31:0] digit,
  output logic [7:0]  dot,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        err
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [15:0] bus_in;
  logic [15:0] sample_p0;
  logic [3:0]  cnt_p0;
  logic        fire_p1;
  logic [7:0]  seen;

  logic [7:0]  lows;
  logic        cap_blanked;
  logic        cap_onehot;
  logic [2:0]  cap_idx;
  logic [6:0]  cap_ga;
  logic        cap_dp;
  logic        cap_blank;
  logic [4:0]  glyph;
  logic        err_evt;
  logic [7:0]  seen_next;

  // {valid, value}; valid = 0 for any pattern that is not one of the 16 hex glyphs
  function automatic logic [4:0] decode_glyph(input logic [6:0] ga);
    logic [4:0] r;
    case (ga)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  assign bus_in = {pos, segments};

  always_comb begin
    lows        = ~sample_p0[15:8];
    cap_blanked = (lows == 8'h00);
    cap_onehot  = $onehot(lows);
    cap_idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (lows[i]) cap_idx = 3'(i);
    end
    cap_ga    = ~sample_p0[6:0];
    cap_dp    = ~sample_p0[7];
    cap_blank = (cap_ga == 7'h00);
    glyph     = decode_glyph(cap_ga);
    err_evt   = fire_p1 && !cap_blanked &&
                (!cap_onehot || (!glyph[4] && !cap_blank));
    seen_next = seen | (8'h01 << cap_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_p0   <= 16'hFFFF;
      cnt_p0      <= 4'd0;
      fire_p1     <= 1'b0;
      seen        <= 8'h00;
      digit       <= 32'h0;
      dot         <= 8'h00;
      digit_valid <= 8'h00;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      // Stage 0: sample the bus and track how long it has been unchanged
      sample_p0 <= bus_in;
      if (bus_in != sample_p0)
        cnt_p0 <= 4'd1;
      else if (cnt_p0 != STABLE)
        cnt_p0 <= cnt_p0 + 4'd1;
      fire_p1 <= (bus_in == sample_p0) && (cnt_p0 == STABLE - 4'd1);

      // Stage 1: act on the stable sample exactly once per stable period
      frame_done <= 1'b0;
      if (fire_p1 && cap_onehot) begin
        if (glyph[4]) begin
          digit[{cap_idx, 2'b00} +: 4] <= glyph[3:0];
          dot[cap_idx]                 <= cap_dp;
          digit_valid[cap_idx]         <= 1'b1;
        end else begin
          digit_valid[cap_idx] <= 1'b0;
          if (cap_blank) dot[cap_idx] <= cap_dp;
        end
        if (seen_next == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= 8'h00;
        end else begin
          seen <= seen_next;
        end
      end

      if (err_evt)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before capture (legal range 2..15).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pos  input  8  digit anode select, active-low, bit i = digit i.
REQ-005 SHALL have port segments  input  8  active-low segments: [0]=a … [6]=g, [7]=dp.
REQ-006 SHALL have port err_clr  input  1  clears err.
REQ-007 SHALL have port digit  output  32  decoded values, digit i at bits [4i+3:4i].
REQ-008 SHALL have port dot  output  8  decimal point lit, per digit, active-high.
REQ-009 SHALL have port digit_valid  output  8  digit i holds a decoded hex glyph.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when all 8 positions have been captured.
REQ-011 SHALL have port err  output  1  sticky protocol error flag.

Function
REQ-012 SHALL register {pos, segments} into a sample register every cycle.
REQ-013 SHALL keep a saturating stability count: 1 when the sample differs from the previous sample, else +1, saturating at STABLE_CYCLES.
REQ-014 SHALL perform exactly one capture per stable period: in the cycle the count first reaches STABLE_CYCLES. Results are registered, so outputs change at the (STABLE_CYCLES+1)th rising edge after the inputs settle.
REQ-015 SHALL ignore the capture (no output change) when pos = 8'hFF (all digits blanked).
REQ-016 SHALL, on capture with exactly one pos bit low (index i), decode g..a = ~segments[6:0] as: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
REQ-017 SHALL, on a valid glyph, write digit[i] = value, dot[i] = ~segments[7], digit_valid[i] = 1.
REQ-018 SHALL, on a blank glyph (g..a = 00), write digit_valid[i] = 0 and dot[i] = ~segments[7], leave digit[i] unchanged, and not flag an error.
REQ-019 SHALL, on any other glyph, write digit_valid[i] = 0, leave digit[i] and dot[i] unchanged, and set err.
REQ-020 SHALL, on capture with two or more pos bits low, set err, leave all digit/dot/digit_valid unchanged, and not mark any position seen.
REQ-021 SHALL mark position i in an 8-bit seen mask on every one-hot capture (valid, blank or invalid glyph).
REQ-022 SHALL, when a capture completes the mask to 8'hFF, pulse frame_done high for exactly the next cycle and clear the mask in that same cycle.
REQ-023 SHALL not mark a position twice: a repeated capture of an already-seen position leaves the mask unchanged.
REQ-024 SHALL clear err on err_clr; an error event in the same cycle takes priority and err stays 1.
REQ-025 SHALL update outputs only on captures; input glitches shorter than STABLE_CYCLES samples produce no output change.

Reset
REQ-026 SHALL, while rst = 1 at a clock edge, set digit = 0, dot = 0, digit_valid = 0, frame_done = 0, err = 0, seen mask = 0, stability count = 0, and sample register = {8'hFF, 8'hFF}.
REQ-027 SHALL discard any stability period that spans reset; counting restarts from the first post-reset sample.
REQ-028 SHALL capture no data while rst = 1.

Verification
REQ-029 SHALL verify: pos = 8'hFE, segments = 8'hC0 held 5 cycles -> at edge 5, digit[3:0] = 0, digit_valid[0] = 1, dot[0] = 0, err = 0.
REQ-030 SHALL verify: scan all 8 positions, each held 6 cycles, digit i showing value i+1, dot on position 7 only (segments[7] = 0) -> digit = 32'h87654321, dot = 8'h80, one frame_done pulse after the 8th capture.
REQ-031 SHALL verify: pos = 8'hFC (two anodes low) held stable -> err = 1 and outputs unchanged; then err_clr for 1 cycle -> err = 0.
REQ-032 SHALL verify: pos = 8'hF7, segments = 8'hFF held -> digit_valid[3] = 0 and err = 0; then segments = 8'h00 (all lit, g..a = 7F) held -> digit[15:12] = 8, dot[3] = 1.
REQ-033 SHALL verify: a 3-cycle glitch to pos = 8'hBF inside a stable position-0 period -> no change to digit[27:24] and no err; the stable position-0 value is captured again normally after the glitch.
REQ-034 SHALL verify: rst asserted mid-frame after 4 captures -> all outputs 0; frame_done asserts only after 8 fresh post-reset captures.
